// File: rtl/text_framebuffer.sv
// Text-mode character RAM for the video path. A writer FSM paints the static
// header/labels after reset, then keeps each track's note key shown as two hex digits.
module text_framebuffer #(
   parameter int COLS   = 80,
   parameter int ROWS   = 30,
   parameter int TRACKS = 4,
   parameter int KEY_W  = 7,
   parameter int POS_W  = 12
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [TRACKS*KEY_W-1:0]   keys,
   input  logic [POS_W-1:0]          pos,
   output logic [7:0]                char,
   output logic                      ready
);

   localparam int DEPTH = COLS*ROWS;
   localparam int TW    = (TRACKS > 1) ? $clog2(TRACKS) : 1;

   typedef enum logic [2:0] {CLEAR, HEADER, LABEL, SCAN, WR_HI, WR_LO} state_t;

   state_t            r_state;
   logic [POS_W-1:0]  r_addr;
   logic [3:0]        r_col;
   logic [TW-1:0]     r_trk;
   logic              r_ready;
   logic [TRACKS-1:0] r_dirty;
   logic [KEY_W-1:0]  r_shadow [TRACKS];
   logic [KEY_W-1:0]  r_latch;
   logic [7:0]        r_char;
   logic [7:0]        r_ram [DEPTH];

   logic              w_we;
   logic [POS_W-1:0]  w_waddr;
   logic [7:0]        w_wdata;
   logic [POS_W-1:0]  w_row_base;
   logic [KEY_W-1:0]  w_key;
   logic [TW-1:0]     w_trk_nxt;
   logic [3:0]        w_hi;

   function automatic logic [7:0] f_hex(input logic [3:0] v);
      return (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h37 + {4'h0, v});
   endfunction

   function automatic logic [7:0] f_hdr(input logic [3:0] i);
      case (i)
         4'd0:    return "M";
         4'd1:    return "I";
         4'd2:    return "D";
         4'd3:    return "I";
         4'd5:    return "S";
         4'd6:    return "e";
         4'd7:    return "q";
         4'd8:    return "u";
         4'd9:    return "e";
         4'd10:   return "n";
         4'd11:   return "c";
         4'd12:   return "e";
         4'd13:   return "r";
         default: return 8'h20;
      endcase
   endfunction

   function automatic logic [7:0] f_lbl(input logic [3:0] c, input logic [TW-1:0] t);
      case (c)
         4'd0:    return "T";
         4'd1:    return "r";
         4'd2:    return "a";
         4'd3:    return "c";
         4'd4:    return "k";
         4'd6:    return 8'h31 + 8'(t);
         4'd7:    return ":";
         4'd9:    return 8'hB0;
         4'd10:   return 8'hF8;
         default: return 8'h20;
      endcase
   endfunction

   assign w_row_base = POS_W'((int'(r_trk) + 2) * COLS);
   assign w_key      = keys[r_trk*KEY_W +: KEY_W];
   assign w_trk_nxt  = (r_trk == TW'(TRACKS-1)) ? '0 : r_trk + 1'b1;
   assign w_hi       = 4'(r_latch[KEY_W-1:4]);

   always_comb begin
      w_we    = 1'b0;
      w_waddr = '0;
      w_wdata = 8'h20;
      case (r_state)
         CLEAR:  begin w_we = 1'b1; w_waddr = r_addr; end
         HEADER: begin w_we = 1'b1; w_waddr = POS_W'(r_col); w_wdata = f_hdr(r_col); end
         LABEL:  begin w_we = 1'b1; w_waddr = w_row_base + POS_W'(r_col); w_wdata = f_lbl(r_col, r_trk); end
         WR_HI:  begin w_we = 1'b1; w_waddr = w_row_base + POS_W'(11); w_wdata = f_hex(w_hi) | 8'h80; end
         WR_LO:  begin w_we = 1'b1; w_waddr = w_row_base + POS_W'(12); w_wdata = f_hex(r_latch[3:0]) | 8'h80; end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= CLEAR;
         r_addr  <= '0;
         r_col   <= '0;
         r_trk   <= '0;
         r_ready <= 1'b0;
         r_dirty <= '1;
         r_latch <= '0;
         for (int i = 0; i < TRACKS; i++) r_shadow[i] <= '0;
      end else begin
         case (r_state)
            CLEAR: begin
               if (r_addr == POS_W'(DEPTH-1)) begin
                  r_state <= HEADER;
                  r_col   <= '0;
               end else begin
                  r_addr <= r_addr + 1'b1;
               end
            end
            HEADER: begin
               if (r_col == 4'd13) begin
                  r_state <= LABEL;
                  r_col   <= '0;
                  r_trk   <= '0;
               end else begin
                  r_col <= r_col + 1'b1;
               end
            end
            LABEL: begin
               if (r_col == 4'd10) begin
                  r_col <= '0;
                  if (r_trk == TW'(TRACKS-1)) begin
                     r_trk   <= '0;
                     r_ready <= 1'b1;
                     r_state <= SCAN;
                  end else begin
                     r_trk <= r_trk + 1'b1;
                  end
               end else begin
                  r_col <= r_col + 1'b1;
               end
            end
            SCAN: begin
               // Both digits come from r_latch, so a key change mid-write cannot tear the pair.
               if (r_dirty[r_trk] || (w_key != r_shadow[r_trk])) begin
                  r_shadow[r_trk] <= w_key;
                  r_latch         <= w_key;
                  r_dirty[r_trk]  <= 1'b0;
                  r_state         <= WR_HI;
               end else begin
                  r_trk <= w_trk_nxt;
               end
            end
            WR_HI: r_state <= WR_LO;
            WR_LO: begin
               r_trk   <= w_trk_nxt;
               r_state <= SCAN;
            end
            default: r_state <= CLEAR;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_we) r_ram[w_waddr] <= w_wdata;
   end

   // Separate read process: a same-address write in this cycle returns the old byte.
   always_ff @(posedge clk) begin
      if (rst)                                 r_char <= 8'h20;
      else if (!r_ready || int'(pos) >= DEPTH) r_char <= 8'h20;
      else                                     r_char <= r_ram[pos];
   end

   assign char  = r_char;
   assign ready = r_ready;

endmodule
